line_buf_ctrl: RTL and testbench

LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

---
 rtl/line_buf_ctrl.sv | 155 +++++++++++++++
 tb/tb_line_buf_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/line_buf_ctrl.sv
// Line buffer controller: write/read pointer generation for a one-line delay tap.
// Optional power-up zero sweep of the buffer is enabled by defining LINE_BUF_CLEAR_EN.
module line_buf_ctrl #(
    parameter int LINE_LEN   = 1264,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pix_valid,
    input  logic                  line_start,
    input  logic                  err_clr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic                  mem_wr_zero,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                  tap_valid,
    output logic                  busy,
    output logic                  primed,
    output logic                  line_err
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] TAP_OFS   = ADDR_WIDTH'(LINE_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] FILL_LAST = ADDR_WIDTH'(LINE_LEN - 1);
    localparam logic [CNT_W-1:0]      LEN_CNT   = CNT_W'(LINE_LEN);
    localparam logic [CNT_W-1:0]      CNT_MAX   = '1;

`ifdef LINE_BUF_CLEAR_EN
    typedef enum logic [1:0] {CLEAR, PRIME, RUN, RESYNC} state_t;
    localparam state_t RST_STATE = CLEAR;
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = '1;
    logic [ADDR_WIDTH-1:0] clr_cnt, clr_nxt;
`else
    typedef enum logic [1:0] {PRIME, RUN, RESYNC} state_t;
    localparam state_t RST_STATE = PRIME;
`endif

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] fill_cnt, fill_nxt;
    logic [CNT_W-1:0]      pix_cnt, pix_nxt, pix_step;
    logic                  err_nxt;
    logic                  rd_vld_p1;

    assign mem_rd_addr = wr_ptr - TAP_OFS;
    assign tap_valid   = rd_vld_p1;
    assign primed      = (state == RUN);

    // line_start restarts the count, with a same-cycle pixel counted as the first
    always_comb begin
        pix_step = pix_cnt;
        if (line_start)
            pix_step = {{(CNT_W-1){1'b0}}, pix_valid};
        else if (pix_valid && pix_cnt != CNT_MAX)
            pix_step = pix_cnt + 1'b1;
    end

    always_comb begin
        state_nxt   = state;
        wr_ptr_nxt  = wr_ptr;
        fill_nxt    = fill_cnt;
        pix_nxt     = pix_cnt;
        err_nxt     = line_err & ~err_clr;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_wr_zero = 1'b0;
        mem_wr_addr = wr_ptr;
        busy        = 1'b0;
`ifdef LINE_BUF_CLEAR_EN
        clr_nxt     = clr_cnt;
`endif
        case (state)
`ifdef LINE_BUF_CLEAR_EN
            CLEAR: begin
                mem_we      = 1'b1;
                mem_wr_zero = 1'b1;
                mem_wr_addr = clr_cnt;
                busy        = 1'b1;
                clr_nxt     = clr_cnt + 1'b1;
                if (clr_cnt == CLR_LAST) begin
                    state_nxt  = PRIME;
                    wr_ptr_nxt = '0;
                    fill_nxt   = '0;
                end
            end
`endif
            PRIME: begin
                mem_we  = pix_valid;
                pix_nxt = pix_step;
                if (pix_valid) begin
                    wr_ptr_nxt = wr_ptr + 1'b1;
                    fill_nxt   = fill_cnt + 1'b1;
                    // the final priming write also fetches address 0, so pixel 0
                    // emerges alongside pixel LINE_LEN
                    if (fill_cnt == FILL_LAST) begin
                        mem_re    = 1'b1;
                        fill_nxt  = '0;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                mem_we  = pix_valid;
                mem_re  = pix_valid;
                pix_nxt = pix_step;
                if (pix_valid)
                    wr_ptr_nxt = wr_ptr + 1'b1;
                if (line_start && pix_cnt != LEN_CNT) begin
                    err_nxt    = 1'b1;
                    state_nxt  = RESYNC;
                    wr_ptr_nxt = '0;
                    fill_nxt   = '0;
                end
            end
            RESYNC: begin
                pix_nxt = pix_step;
                // wr_ptr is already 0 here, so the line_start pixel lands at address 0
                if (line_start) begin
                    mem_we     = pix_valid;
                    state_nxt  = PRIME;
                    wr_ptr_nxt = pix_valid ? ADDR_WIDTH'(1) : '0;
                    fill_nxt   = pix_valid ? ADDR_WIDTH'(1) : '0;
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    // state and pointer registers; read-valid pipeline stage p1
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= RST_STATE;
            wr_ptr    <= '0;
            fill_cnt  <= '0;
            pix_cnt   <= '0;
            line_err  <= 1'b0;
            rd_vld_p1 <= 1'b0;
`ifdef LINE_BUF_CLEAR_EN
            clr_cnt   <= '0;
`endif
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            fill_cnt  <= fill_nxt;
            pix_cnt   <= pix_nxt;
            line_err  <= err_nxt;
            rd_vld_p1 <= mem_re;
`ifdef LINE_BUF_CLEAR_EN
            clr_cnt   <= clr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Randomized self-checking bench for line_buf_ctrl (LINE_LEN=8, ADDR_WIDTH=4) with a pixel-history model.
module tb_line_buf_ctrl;

    localparam int LL = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;
`ifdef LINE_BUF_CLEAR_EN
    localparam int CLR = 1;
`else
    localparam int CLR = 0;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          pix_valid = 1'b0;
    logic          line_start = 1'b0;
    logic          err_clr = 1'b0;
    logic [7:0]    pix_data = 8'd0;
    logic          mem_we, mem_wr_zero, mem_re, tap_valid, busy, primed, line_err;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;

    logic [7:0]    mem [0:DEPTH-1];
    logic [7:0]    rd_data;

    int errors = 0;
    int checks = 0;

    line_buf_ctrl #(.LINE_LEN(LL), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset_n(reset_n), .pix_valid(pix_valid),
        .line_start(line_start), .err_clr(err_clr), .mem_we(mem_we),
        .mem_wr_addr(mem_wr_addr), .mem_wr_zero(mem_wr_zero), .mem_re(mem_re),
        .mem_rd_addr(mem_rd_addr), .tap_valid(tap_valid), .busy(busy),
        .primed(primed), .line_err(line_err)
    );

    always #5 clock = ~clock;

    // buffer memory with synchronous read
    always @(posedge clock) begin
        if (mem_we) mem[mem_wr_addr] <= mem_wr_zero ? 8'd0 : pix_data;
        if (mem_re) rd_data <= mem[mem_rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: counts writes since the last restart and pixels per line
    bit         mdl_ok = 0;
    int         clear_left, m_n, m_len;
    bit         resync, m_err, m_tap;
    logic [7:0] m_tap_data;
    logic [7:0] hist [0:255];

    task automatic model_step();
        bit clearing, e_we, e_re, mism;
        int e_wa, e_ra;
        clearing = 0; e_we = 0; e_re = 0; mism = 0; e_wa = 0; e_ra = 0;
        if (mdl_ok) begin
            clearing = clear_left > 0;
            e_ra = (m_n - (LL - 1)) & (DEPTH - 1);
            if (clearing) begin
                e_we = 1; e_wa = DEPTH - clear_left;
            end else if (resync) begin
                e_we = pix_valid && line_start; e_wa = 0;
            end else begin
                e_we = pix_valid;
                e_wa = m_n % DEPTH;
                e_re = pix_valid && (m_n >= LL - 1);
                mism = line_start && (m_n >= LL) && (m_len != LL);
            end
            chk("mem_we", 32'(mem_we), 32'(e_we));
            if (e_we) chk("mem_wr_addr", 32'(mem_wr_addr), 32'(e_wa));
            chk("mem_re", 32'(mem_re), 32'(e_re));
            if (e_re) chk("mem_rd_addr", 32'(mem_rd_addr), 32'(e_ra));
            chk("mem_wr_zero", 32'(mem_wr_zero), 32'(clearing));
            chk("busy", 32'(busy), 32'(clearing));
            chk("primed", 32'(primed), 32'(!clearing && !resync && m_n >= LL));
            chk("tap_valid", 32'(tap_valid), 32'(m_tap));
            chk("line_err", 32'(line_err), 32'(m_err));
            if (m_tap) chk("tap_data", 32'(rd_data), 32'(m_tap_data));
        end
        if (!reset_n) begin
            clear_left = CLR ? DEPTH : 0;
            resync = 0; m_n = 0; m_len = 0; m_err = 0; m_tap = 0;
            mdl_ok = 1;
        end else if (mdl_ok) begin
            m_err = (m_err && !err_clr) || mism;
            m_tap = e_re;
            if (e_re) m_tap_data = hist[(m_n - (LL - 1)) & 255];
            if (clearing) begin
                clear_left--;
            end else begin
                if (line_start) m_len = int'(pix_valid);
                else if (pix_valid && m_len < 31) m_len++;
                if (resync) begin
                    if (line_start) begin
                        resync = 0; m_n = 0;
                        if (pix_valid) begin hist[0] = pix_data; m_n = 1; end
                    end
                end else begin
                    if (pix_valid) begin hist[m_n & 255] = pix_data; m_n++; end
                    if (mism) begin resync = 1; m_n = 0; end
                end
            end
        end
    endtask

    initial forever begin
        @(negedge clock);
        model_step();
    end

    task automatic step(input bit p, input bit l, input bit c, input logic [7:0] d);
        pix_valid = p; line_start = l; err_clr = c; pix_data = d;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 8'($urandom));
    endtask

    task automatic line(input int len);
        for (int i = 0; i < len; i++) step(1, i == 0, 0, 8'($urandom));
    endtask

    initial begin
        reset_n = 1'b0;
        idle(3);
        chk("rst_tap_valid", 32'(tap_valid), 32'd0);
        chk("rst_primed", 32'(primed), 32'd0);
        chk("rst_line_err", 32'(line_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'(CLR));
        reset_n = 1'b1;
        if (CLR != 0) begin
            idle(DEPTH);
            chk("clear_done_busy", 32'(busy), 32'd0);
        end
        idle(2);

        // first line: pixel 0 must reappear as the first tap word
        step(1, 1, 0, 8'h5A);
        for (int i = 1; i < LL; i++) step(1, 0, 0, 8'($urandom));
        chk("primed_after_8", 32'(primed), 32'd1);
        chk("first_tap_valid", 32'(tap_valid), 32'd1);
        chk("first_tap_data", 32'(rd_data), 32'h5A);

        for (int ln = 0; ln < 20; ln++) line(LL);
        chk("lines_ok_err", 32'(line_err), 32'd0);

        // short line forces a resync
        line(LL - 1);
        step(1, 1, 0, 8'($urandom));
        chk("short_line_err", 32'(line_err), 32'd1);
        chk("short_line_primed", 32'(primed), 32'd0);
        step(1, 0, 0, 8'($urandom));
        step(1, 0, 0, 8'($urandom));
        step(1, 1, 0, 8'($urandom));
        chk("resync_wr_addr", 32'(mem_wr_addr), 32'd1);

        step(0, 0, 1, 8'd0);
        chk("err_clr", 32'(line_err), 32'd0);
        for (int i = 1; i < LL; i++) step(1, 0, 0, 8'($urandom));
        line(LL);
        line(LL + 1);
        step(1, 1, 1, 8'($urandom));
        chk("err_clr_with_error", 32'(line_err), 32'd1);

        // reset in the middle of priming
        step(1, 1, 0, 8'($urandom));
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'($urandom));
        reset_n = 1'b0;
        step(0, 0, 0, 8'd0);
        chk("midrst_primed", 32'(primed), 32'd0);
        chk("midrst_tap_valid", 32'(tap_valid), 32'd0);
        chk("midrst_line_err", 32'(line_err), 32'd0);
        chk("midrst_wr_addr", 32'(mem_wr_addr), 32'd0);
        reset_n = 1'b1;
        if (CLR != 0) idle(DEPTH);

        // randomized lines with gaps, wrong lengths and error clears
        for (int ln = 0; ln < 300; ln++) begin
            int len;
            int sent;
            bit first;
            len = ($urandom % 10 < 8) ? LL : int'($urandom_range(5, 11));
            sent = 0;
            first = 1;
            while (sent < len) begin
                bit p;
                p = ($urandom % 10) < 7;
                if (first && !p && ($urandom % 4 != 0)) p = 1;
                step(p, first, ($urandom % 16) == 0, 8'($urandom));
                first = 0;
                if (p) sent++;
            end
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
